// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    localparam int OVERSAMPLE       = 8;
    localparam int OVERSAMPLE_SHIFT = 3;
    localparam int CNT_W            = 19;

    // Counter reload for (prescale << sh) cycles, counting down to zero.
    function automatic logic [CNT_W-1:0] reload(
        input logic [15:0] p,
        input int unsigned sh
    );
        logic [CNT_W-1:0] w;
        w = CNT_W'(p) << sh;
        return w - 1'b1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line (idles high).
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8x oversampled frame FSM with an AXI-Stream style output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    logic rxs;

    uart_rx_sync u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rxd),
        .q_o   (rxs)
    );

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [15:0]           pre_q, pre_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  ovr_q, ovr_d;
    logic                  fe_q, fe_d;
    logic                  done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pre_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ovr_q    <= ovr_d;
            fe_q     <= fe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        ovr_d    = 1'b0;
        fe_d     = 1'b0;
        done     = 1'b0;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (!rxs && prescale != 16'd0) begin
                    state_d = START;
                    pre_d   = prescale;
                    cnt_d   = reload(prescale, OVERSAMPLE_SHIFT - 1);
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = reload(pre_q, OVERSAMPLE_SHIFT);
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = reload(pre_q, OVERSAMPLE_SHIFT);
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake in the same cycle frees the slot, so no overrun then.
        if (done) begin
            tdata_d  = shift_q;
            tvalid_d = 1'b1;
            ovr_d    = tvalid_q && !m_axis_tready;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != IDLE);
    assign overrun_error = ovr_q;
    assign frame_error   = fe_q;

endmodule
